// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared types and helpers for the multi-channel edge detector
//
// Purpose: per-channel FSM state encoding, edge-select encoding and the
//          helper that decides whether a pulse is an enabled event.
package edge_det_pkg;

  typedef enum logic [1:0] {ST_LO, PEND_HI, ST_HI, PEND_LO} edge_st_t;
  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_sel_t;

  // A pulse counts as an event only when its direction is selected.
  function automatic logic edge_enabled(input logic [1:0] sel, input logic rise, input logic fall);
    edge_sel_t s;
    s = edge_sel_t'(sel);
    case (s)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_det_ch.sv
// rtl/edge_det_ch.sv - one channel: input register, hysteresis comparator, debounce FSM, event counter
//
// Purpose: samples one code, debounces the comparator decision and emits
//          one-cycle edge pulses plus a saturating event count.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              1 = run, 0 = hold all state (pulses forced low)
//   code            channel code input
//   thr_hi, thr_lo  hysteresis thresholds
//   edge_sel        which pulse directions count as events
//   cnt_clr         clear the event counter
//   level           debounced level
//   rise, fall      one-cycle edge pulses (not gated by edge_sel)
//   evt             current pulse is an enabled event
//   cnt             saturating event counter
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int DW    = 12,
  parameter int DEB   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DW-1:0]    code,
  input  logic [DW-1:0]    thr_hi,
  input  logic [DW-1:0]    thr_lo,
  input  logic [1:0]       edge_sel,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             evt,
  output logic [CNT_W-1:0] cnt
);

  localparam int DCW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]  a_q;
  edge_st_t       state, state_nx;
  logic [DCW-1:0] deb_cnt, deb_nx;
  logic           rise_nx, fall_nx;
  logic           cand;

  // Level is high in ST_HI and while a fall is still being debounced.
  assign level = (state == ST_HI) || (state == PEND_LO);
  assign evt   = edge_enabled(edge_sel, rise, fall);

  // Between the thresholds the comparator agrees with the current level,
  // so the mid band never starts or sustains a pending flip.
  always_comb begin
    cand = level;
    if (thr_lo >= thr_hi)     cand = (a_q >= thr_hi);
    else if (a_q >= thr_hi)   cand = 1'b1;
    else if (a_q <= thr_lo)   cand = 1'b0;
  end

  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      ST_LO: if (cand) begin
        if (DEB == 1) begin
          state_nx = ST_HI;
          rise_nx  = 1'b1;
        end else begin
          state_nx = PEND_HI;
          deb_nx   = DCW'(1);
        end
      end
      PEND_HI: begin
        if (!cand) begin
          state_nx = ST_LO;
          deb_nx   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = ST_HI;
          deb_nx   = '0;
          rise_nx  = 1'b1;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      ST_HI: if (!cand) begin
        if (DEB == 1) begin
          state_nx = ST_LO;
          fall_nx  = 1'b1;
        end else begin
          state_nx = PEND_LO;
          deb_nx   = DCW'(1);
        end
      end
      PEND_LO: begin
        if (cand) begin
          state_nx = ST_HI;
          deb_nx   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = ST_LO;
          deb_nx   = '0;
          fall_nx  = 1'b1;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_LO;
        deb_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      state   <= ST_LO;
      deb_cnt <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      cnt     <= '0;
    end else if (en) begin
      a_q     <= code;
      state   <= state_nx;
      deb_cnt <= deb_nx;
      rise    <= rise_nx;
      fall    <= fall_nx;
      // A clear coinciding with an event keeps that event.
      if (cnt_clr)                    cnt <= evt ? CNT_W'(1) : '0;
      else if (evt && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_detector_mc.sv
// rtl/edge_detector_mc.sv - N-channel debounced hysteresis edge detector with counters and irq
//
// Purpose: replicates edge_det_ch per channel, muxes the selected counter
//          and keeps a sticky interrupt for enabled edge events.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   en            1 = detect, 0 = freeze channel state
//   a_in          channel codes, channel i at [i*DW +: DW]
//   thr_hi/lo     hysteresis thresholds
//   edge_sel      01 rise, 10 fall, 11 both, 00 none (counters and irq)
//   cnt_clr       per-channel counter clear
//   cnt_sel       counter read select
//   irq_ack       clears irq
//   level         debounced level per channel
//   rising_edge   one-cycle rise pulses
//   falling_edge  one-cycle fall pulses
//   cnt_rd        counter of channel cnt_sel
//   irq           sticky interrupt
module edge_detector_mc
  import edge_det_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 12,
  parameter int DEB   = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH*DW-1:0]      a_in,
  input  logic [DW-1:0]           thr_hi,
  input  logic [DW-1:0]           thr_lo,
  input  logic [1:0]              edge_sel,
  input  logic [N_CH-1:0]         cnt_clr,
  input  logic [$clog2(N_CH)-1:0] cnt_sel,
  input  logic                    irq_ack,
  output logic [N_CH-1:0]         level,
  output logic [N_CH-1:0]         rising_edge,
  output logic [N_CH-1:0]         falling_edge,
  output logic [CNT_W-1:0]        cnt_rd,
  output logic                    irq
);

  logic [N_CH-1:0]  evt;
  logic [CNT_W-1:0] cnt_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch #(.DW(DW), .DEB(DEB), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .code     (a_in[i*DW +: DW]),
      .thr_hi   (thr_hi),
      .thr_lo   (thr_lo),
      .edge_sel (edge_sel),
      .cnt_clr  (cnt_clr[i]),
      .level    (level[i]),
      .rise     (rising_edge[i]),
      .fall     (falling_edge[i]),
      .evt      (evt[i]),
      .cnt      (cnt_arr[i])
    );
  end

  assign cnt_rd = cnt_arr[cnt_sel];

  // Setting wins over ack so an event arriving with the ack is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n)             irq <= 1'b0;
    else if (en && |evt)    irq <= 1'b1;
    else if (irq_ack)       irq <= 1'b0;
  end

endmodule

// File: tb/tb_edge_detector_mc.sv
// tb/tb_edge_detector_mc.sv - self-checking bench for edge_detector_mc
module tb_edge_detector_mc;

  localparam int N_CH  = 4;
  localparam int DW    = 12;
  localparam int DEB   = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [N_CH*DW-1:0] a_in;
  logic [DW-1:0]      thr_hi, thr_lo;
  logic [1:0]         edge_sel;
  logic [N_CH-1:0]    cnt_clr;
  logic [1:0]         cnt_sel;
  logic               irq_ack;
  logic [N_CH-1:0]    level, rising_edge, falling_edge;
  logic [CNT_W-1:0]   cnt_rd;
  logic               irq;

  always #5 clk = ~clk;

  edge_detector_mc #(.N_CH(N_CH), .DW(DW), .DEB(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .edge_sel(edge_sel), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .irq_ack(irq_ack),
    .level(level), .rising_edge(rising_edge), .falling_edge(falling_edge),
    .cnt_rd(cnt_rd), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sampled code, debounced level, length of the current
  // disagreement streak, visible pulses, event counts and irq.
  int m_aq  [N_CH];
  bit m_lvl [N_CH];
  int m_run [N_CH];
  bit m_rise[N_CH];
  bit m_fall[N_CH];
  int m_cnt [N_CH];
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cand_of(input int code, input bit lvl);
    int hi = int'(thr_hi);
    int lo = int'(thr_lo);
    if (lo >= hi)   return code >= hi;
    if (code >= hi) return 1'b1;
    if (code <= lo) return 1'b0;
    return lvl;
  endfunction

  task automatic tick();
    bit any_ev, ev, c;
    logic [N_CH-1:0] lv, rs, fl;
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_aq[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_cnt[i] = 0;
      end
      m_irq = 0;
    end else if (en) begin
      any_ev = 0;
      for (int i = 0; i < N_CH; i++) begin
        ev = (m_rise[i] && edge_sel[0]) || (m_fall[i] && edge_sel[1]);
        any_ev |= ev;
        if (cnt_clr[i])               m_cnt[i] = ev ? 1 : 0;
        else if (ev && m_cnt[i] < CMAX) m_cnt[i]++;
      end
      m_irq = any_ev ? 1'b1 : (m_irq && !irq_ack);
      for (int i = 0; i < N_CH; i++) begin
        c = cand_of(m_aq[i], m_lvl[i]);
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (c != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i]  = c;
            m_run[i]  = 0;
            m_rise[i] = c;
            m_fall[i] = !c;
          end
        end else begin
          m_run[i] = 0;
        end
        m_aq[i] = int'(a_in[i*DW +: DW]);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        m_rise[i] = 0; m_fall[i] = 0;
      end
      m_irq = m_irq && !irq_ack;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) begin
      lv[i] = m_lvl[i]; rs[i] = m_rise[i]; fl[i] = m_fall[i];
    end
    chk("level", level, lv);
    chk("rising_edge", rising_edge, rs);
    chk("falling_edge", falling_edge, fl);
    chk("irq", irq, m_irq);
    chk("cnt_rd", cnt_rd, m_cnt[cnt_sel]);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ch(input int ch, input int v);
    a_in[ch*DW +: DW] = v[DW-1:0];
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N_CH; i++) set_ch(i, v);
  endtask

  task automatic wait_pulse(input int ch, input bit want_rise);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      seen = want_rise ? rising_edge[ch] : falling_edge[ch];
    end
    chk("pulse_timeout", seen, 1);
  endtask

  task automatic ack();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  initial begin
    rst_n = 0; en = 1; thr_hi = 12'd2048; thr_lo = 12'd1024; edge_sel = 2'b11;
    cnt_clr = '0; cnt_sel = '0; irq_ack = 0;
    set_all(4095);

    // 1 reset and first-transaction latency
    run(2);
    chk("rst_level", level, 0);
    chk("rst_pulses", rising_edge | falling_edge, 0);
    chk("rst_cnt", cnt_rd, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1;
    run(3);
    chk("lat_early", rising_edge, 0);
    tick();
    chk("lat_rise", rising_edge, 4'hF);
    tick();
    chk("lat_one_cycle", rising_edge, 0);
    chk("lat_irq", irq, 1);

    // 2 hysteresis on ch0
    set_ch(0, 0); run(6); ack();
    set_ch(0, 1500); run(6); chk("hys_1500_lo", level[0], 0);
    set_ch(0, 2100); run(6); chk("hys_2100", level[0], 1);
    set_ch(0, 1500); run(6); chk("hys_1500_hi", level[0], 1);
    set_ch(0, 900);  run(3); chk("hys_900_pending", level[0], 1);
    tick();          chk("hys_900_fall", level[0], 0);

    // 3 glitch rejection on ch1
    set_ch(1, 0); run(6);
    cnt_sel = 2'd1; cnt_clr[1] = 1; tick(); cnt_clr[1] = 0;
    set_ch(1, 3000); run(2); set_ch(1, 0); run(5);
    chk("glitch_level", level[1], 0);
    chk("glitch_cnt", cnt_rd, 0);
    set_ch(1, 3000); run(3); set_ch(1, 0); tick();
    chk("deb3_rise", rising_edge[1], 1);
    tick();
    chk("deb3_cnt", cnt_rd, 1);
    run(6);

    // 4 multi-channel and irq ack racing a new pulse
    set_all(0); run(6); ack();
    chk("irq_cleared", irq, 0);
    set_all(3000); run(3);
    chk("multi_early", rising_edge, 0);
    tick(); chk("multi_rise", rising_edge, 4'hF);
    tick(); chk("multi_irq", irq, 1);
    set_ch(0, 0); wait_pulse(0, 0);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("ack_with_pulse", irq, 1);
    ack(); chk("ack_alone", irq, 0);

    // 5 counter saturation, clear with event, rise-only counting
    cnt_sel = 2'd2; set_ch(2, 0); run(6);
    cnt_clr[2] = 1; tick(); cnt_clr[2] = 0;
    for (int t = 0; t < 10; t++) begin
      set_ch(2, 4095); run(4);
      set_ch(2, 0);    run(4);
    end
    run(2);
    chk("cnt_sat", cnt_rd, 15);
    set_ch(2, 4095); wait_pulse(2, 1);
    cnt_clr[2] = 1; tick(); cnt_clr[2] = 0;
    chk("clr_with_evt", cnt_rd, 1);
    run(2);
    edge_sel = 2'b01;
    cnt_clr[2] = 1; tick(); cnt_clr[2] = 0;
    set_ch(2, 0); run(5); set_ch(2, 4095); run(5);
    set_ch(2, 0); run(5); set_ch(2, 4095); run(5);
    chk("rise_only_cnt", cnt_rd, 2);
    edge_sel = 2'b11;

    // 6 freeze mid-debounce on ch3
    set_ch(3, 0); run(6);
    set_ch(3, 3000); run(2);
    en = 0; run(5);
    chk("freeze_level", level[3], 0);
    en = 1; tick();
    chk("freeze_wait", rising_edge[3], 0);
    tick();
    chk("freeze_rise", rising_edge[3], 1);
    run(4);

    // randomized phase against the model
    for (int it = 0; it < 600; it++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      en       = ($urandom_range(0, 9) != 0);
      irq_ack  = ($urandom_range(0, 7) == 0);
      cnt_sel  = 2'($urandom_range(0, 3));
      cnt_clr  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 19) == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        thr_hi = 12'($urandom_range(0, 4095));
        thr_lo = 12'($urandom_range(0, 4095));
      end
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 3) == 0) set_ch(i, int'($urandom_range(0, 4095)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
